// File: rtl/ldpc_syndrome_encoder_if.sv
// Bundle of the neighbour-table write port, the frame control and the serial
// key-bit / syndrome-bit handshakes of the LDPC syndrome encoder.
interface ldpc_syndrome_encoder_if #(
    parameter int log2n = 8,
    parameter int log2m = 7
);
    logic             nb_wr_en;
    logic [log2n-1:0] nb_wr_var;
    logic [1:0]       nb_wr_slot;
    logic [log2m-1:0] nb_wr_chk;

    logic             start;
    logic             busy;

    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;

    logic             syn_valid;
    logic             syn_bit;
    logic             syn_last;
    logic             syn_ready;

    // Side that loads the table, feeds key bits and drains the syndrome
    modport master (
        output nb_wr_en, nb_wr_var, nb_wr_slot, nb_wr_chk,
        output start, bit_valid, bit_in, syn_ready,
        input  busy, bit_ready, syn_valid, syn_bit, syn_last
    );

    // The encoder itself
    modport slave (
        input  nb_wr_en, nb_wr_var, nb_wr_slot, nb_wr_chk,
        input  start, bit_valid, bit_in, syn_ready,
        output busy, bit_ready, syn_valid, syn_bit, syn_last
    );
endinterface

// File: rtl/ldpc_syndrome_encoder.sv
// LDPC syndrome encoder: accumulates s = H * x over GF(2) from a serial key
// bitstream using a programmable variable-node neighbour table, then streams
// the m syndrome bits out serially.
module ldpc_syndrome_encoder #(
    parameter int n     = 204,
    parameter int m     = 102,
    parameter int log2n = 8,
    parameter int log2m = 7,
    parameter int deg_v = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    ldpc_syndrome_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Neighbour table: nb_table[slot][var] holds a check index; all-ones means
    // "no neighbour" as long as it is >= m.
    logic [log2m-1:0] nb_table [deg_v][n];

    logic [m-1:0]     syndrome;
    logic [m-1:0]     flip_mask;

    // Shared counter: key-bit index in ACCUM, syndrome-bit index in SEND
    logic [log2n-1:0] cnt;
    logic [log2m-1:0] out_idx;

    logic             bit_accept;
    logic             syn_xfer;
    logic             last_in;
    logic             last_out;
    logic             wr_ok;

    assign bit_accept = (state == ACCUM) && bus.bit_valid;
    assign syn_xfer   = (state == SEND) && bus.syn_ready;
    assign last_in    = (int'(cnt) == n - 1);
    assign last_out   = (int'(cnt) == m - 1);
    assign out_idx    = cnt[log2m-1:0];

    // Table writes are only honoured between frames and for legal coordinates
    assign wr_ok = (state == IDLE) && bus.nb_wr_en &&
                   (int'(bus.nb_wr_slot) < deg_v) &&
                   (int'(bus.nb_wr_var) < n);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start -> ACCUM, last key bit -> SEND, last syndrome bit -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (bit_accept && last_in) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (syn_xfer && last_out) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are pure functions of state so they are quiet in IDLE and reset
    always_comb begin
        bus.bit_ready = 1'b0;
        bus.syn_valid = 1'b0;
        bus.syn_bit   = 1'b0;
        bus.syn_last  = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            ACCUM: begin
                bus.bit_ready = 1'b1;
                bus.busy      = 1'b1;
            end
            SEND: begin
                bus.syn_valid = 1'b1;
                bus.syn_bit   = syndrome[out_idx];
                bus.syn_last  = last_out;
                bus.busy      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Build the set of check nodes touched by the current variable node; duplicate slots cancel
    always_comb begin
        flip_mask = '0;
        for (int s = 0; s < deg_v; s++) begin
            if (int'(nb_table[s][cnt]) < m) begin
                flip_mask[nb_table[s][cnt][log2m-1:0]] = ~flip_mask[nb_table[s][cnt][log2m-1:0]];
            end
        end
    end

    // Counter and syndrome accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            syndrome <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= '0;
                        syndrome <= '0;
                    end
                end
                ACCUM: begin
                    if (bit_accept) begin
                        if (bus.bit_in) begin
                            syndrome <= syndrome ^ flip_mask;
                        end
                        cnt <= last_in ? '0 : cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (syn_xfer) begin
                        cnt <= last_out ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Neighbour table storage; reset leaves every entry as an ignored index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < deg_v; s++) begin
                for (int v = 0; v < n; v++) begin
                    nb_table[s][v] <= '1;
                end
            end
        end else if (wr_ok) begin
            nb_table[bus.nb_wr_slot][bus.nb_wr_var] <= bus.nb_wr_chk;
        end
    end

endmodule

// File: tb/tb_ldpc_syndrome_encoder.sv
// Directed self-checking bench for the LDPC syndrome encoder.
module tb_ldpc_syndrome_encoder;

    localparam int N     = 204;
    localparam int M     = 102;
    localparam int LOG2N = 8;
    localparam int LOG2M = 7;
    localparam int DEG_V = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;

    int ref_tbl [DEG_V][N];

    ldpc_syndrome_encoder_if #(.log2n(LOG2N), .log2m(LOG2M)) bus ();

    ldpc_syndrome_encoder #(
        .n(N), .m(M), .log2n(LOG2N), .log2m(LOG2M), .deg_v(DEG_V)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Runaway guard
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [M-1:0] observed,
                               input logic [M-1:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [M-1:0] compute_ref(input logic [N-1:0] bits);
        logic [M-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (bits[k]) begin
                for (int s = 0; s < DEG_V; s++) begin
                    if (ref_tbl[s][k] < M) begin
                        r[ref_tbl[s][k]] = ~r[ref_tbl[s][k]];
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic clear_ref();
        for (int s = 0; s < DEG_V; s++) begin
            for (int v = 0; v < N; v++) begin
                ref_tbl[s][v] = 127;
            end
        end
    endtask

    task automatic write_entry(input int v, input int s, input int c);
        bus.nb_wr_en   = 1'b1;
        bus.nb_wr_var  = LOG2N'(v);
        bus.nb_wr_slot = 2'(s);
        bus.nb_wr_chk  = LOG2M'(c);
        @(posedge clk);
        #1;
        bus.nb_wr_en = 1'b0;
        ref_tbl[s][v] = c;
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Feed n_bits key bits; optionally gap bit_valid and attempt a table write at bit wr_at
    task automatic applyStimulus(input logic [N-1:0] bits, input int n_bits,
                                 input bit toggle, input int wr_at);
        int k     = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit accepted;
        while (k < n_bits && guard < 4 * N) begin
            guard++;
            bus.bit_valid = toggle ? phase : 1'b1;
            phase         = ~phase;
            bus.bit_in    = bits[k];
            if (k == wr_at) begin
                bus.nb_wr_en   = 1'b1;
                bus.nb_wr_var  = LOG2N'(9);
                bus.nb_wr_slot = 2'd0;
                bus.nb_wr_chk  = LOG2M'(50);
            end else begin
                bus.nb_wr_en = 1'b0;
            end
            accepted = bus.bit_valid && bus.bit_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                k++;
            end
        end
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.nb_wr_en  = 1'b0;
        checkOutput("bits_accepted", M'(k), M'(n_bits));
    endtask

    // Drain the syndrome, optionally stalling 3 cycles at index stall_at
    task automatic collect_syndrome(input int stall_at, output logic [M-1:0] got);
        int   j          = 0;
        int   guard      = 0;
        int   stall_left = 3;
        int   last_count = 0;
        int   last_pos   = -1;
        logic v, b, l;
        logic held = 1'b0;
        bit   xfer;
        got = '0;
        while (j < M && guard < 4 * M) begin
            guard++;
            v = bus.syn_valid;
            b = bus.syn_bit;
            l = bus.syn_last;
            if (j == stall_at && stall_left > 0) begin
                bus.syn_ready = 1'b0;
                if (stall_left == 3) begin
                    held = b;
                end else begin
                    checkOutput("stall_hold_bit", M'(b), M'(held));
                end
                stall_left--;
            end else begin
                bus.syn_ready = 1'b1;
            end
            xfer = v && bus.syn_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                got[j] = b;
                if (l) begin
                    last_count++;
                    last_pos = j;
                end
                j++;
            end
        end
        bus.syn_ready = 1'b1;
        checkOutput("syn_count", M'(j), M'(M));
        checkOutput("syn_last_count", M'(last_count), M'(1));
        checkOutput("syn_last_pos", M'(last_pos), M'(M - 1));
        if (stall_at >= 0) begin
            checkOutput("stall_delivered_bit", M'(got[stall_at]), M'(held));
        end
        checkOutput("idle_after_frame", M'(bus.busy), M'(0));
    endtask

    task automatic run_frame(input logic [N-1:0] bits, input bit toggle,
                             input int stall_at, input int wr_at,
                             output logic [M-1:0] got);
        start_frame();
        checkOutput("busy_in_accum", M'(bus.busy), M'(1));
        checkOutput("ready_in_accum", M'(bus.bit_ready), M'(1));
        applyStimulus(bits, N, toggle, wr_at);
        checkOutput("first_syn_latency", M'(bus.syn_valid), M'(1));
        collect_syndrome(stall_at, got);
    endtask

    // Directed sequence
    initial begin
        logic [N-1:0] pat;
        logic [N-1:0] pat2;
        logic [N-1:0] single;
        logic [M-1:0] got;
        logic [M-1:0] got_ref;
        logic [M-1:0] expv;
        logic         seen_out;

        bus.nb_wr_en   = 1'b0;
        bus.nb_wr_var  = '0;
        bus.nb_wr_slot = '0;
        bus.nb_wr_chk  = '0;
        bus.start      = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_in     = 1'b0;
        bus.syn_ready  = 1'b1;
        clear_ref();

        #2;
        checkOutput("rst_bit_ready", M'(bus.bit_ready), M'(0));
        checkOutput("rst_syn_valid", M'(bus.syn_valid), M'(0));
        checkOutput("rst_syn_bit", M'(bus.syn_bit), M'(0));
        checkOutput("rst_syn_last", M'(bus.syn_last), M'(0));
        checkOutput("rst_busy", M'(bus.busy), M'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] unwritten table, all-ones input");
        pat = '1;
        run_frame(pat, 1'b0, -1, -1, got);
        checkOutput("empty_table_syndrome", got, '0);

        $display("[TB] loading identity-like table");
        for (int v = 0; v < N; v++) begin
            for (int s = 0; s < DEG_V; s++) begin
                write_entry(v, s, (v + s) % M);
            end
        end

        $display("[TB] all-zero input");
        pat = '0;
        run_frame(pat, 1'b0, -1, -1, got);
        checkOutput("zero_input_syndrome", got, '0);

        $display("[TB] only bit 0 set");
        single    = '0;
        single[0] = 1'b1;
        expv      = 'h7;
        run_frame(single, 1'b0, -1, -1, got);
        checkOutput("bit0_syndrome", got, expv);

        $display("[TB] var 5 slots 7,7,9");
        write_entry(5, 0, 7);
        write_entry(5, 1, 7);
        write_entry(5, 2, 9);
        single    = '0;
        single[5] = 1'b1;
        expv      = 'h200;
        run_frame(single, 1'b0, -1, -1, got);
        checkOutput("dup_cancel_syndrome", got, expv);

        $display("[TB] mixed pattern, no stall then with stalls");
        pat = {51{4'b1011}};
        run_frame(pat, 1'b0, -1, -1, got_ref);
        checkOutput("pattern_model", got_ref, compute_ref(pat));
        run_frame(pat, 1'b1, 50, -1, got);
        checkOutput("stall_equals_nostall", got, got_ref);

        $display("[TB] reset in the middle of a frame");
        start_frame();
        applyStimulus(pat, 100, 1'b0, -1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", M'(bus.busy), M'(0));
        checkOutput("midrst_bit_ready", M'(bus.bit_ready), M'(0));
        checkOutput("midrst_syn_valid", M'(bus.syn_valid), M'(0));
        clear_ref();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen_out = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            seen_out = seen_out | bus.syn_valid | bus.busy;
        end
        checkOutput("no_output_after_abandon", M'(seen_out), M'(0));

        for (int v = 0; v < 20; v++) begin
            write_entry(v, 0, (v * 3) % M);
            write_entry(v, 1, v + 40);
            write_entry(v, 2, M - 1 - v);
        end
        pat2 = {17{12'hA5C}};
        run_frame(pat2, 1'b0, -1, 30, got);
        checkOutput("second_frame_model", got, compute_ref(pat2));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
